// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Pipeline sequencer for the 5-stage RISC-V core, placed beside the forwarding unit.
//  - inserts a one-cycle bubble for load-use hazards that forwarding cannot cover
//  - squashes the wrong-path IF/ID and ID/EX contents on a taken branch or jump
//  - freezes the front of the pipe while the multi-cycle MUL/DIV unit in EX runs,
//    with a watchdog that releases the pipe and raises a sticky error flag
// Optional build macro: HZD_PERF_EN adds stall-cycle and branch-flush counters.
// Without it, the counter ports remain present and read as zero.
//
// State table
//   state     | meaning
//   ST_RUN    | normal flow; load-use / branch / MUL-DIV start decisions
//   ST_MDWAIT | MUL/DIV in flight; front frozen until done or watchdog expiry
//
// Control outputs are Mealy (combinational from state and inputs). While rst is
// high, the pipe is held open: all enables are 1 and all flushes and pulses are 0.

module hazard_stall_ctrl #(
    parameter int MD_MAX_CYC = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IDEXmemReadIn,
    input  logic [4:0]       IDEXrdIn,
    input  logic             IDEXmdIn,
    input  logic [4:0]       IFIDrs1In,
    input  logic [4:0]       IFIDrs2In,
    input  logic             IFIDuse1In,
    input  logic             IFIDuse2In,
    input  logic             branchTakenIn,
    input  logic             mdDoneIn,
    output logic             pcWriteOut,
    output logic             IFIDwriteOut,
    output logic             IFIDflushOut,
    output logic             IDEXwriteOut,
    output logic             IDEXflushOut,
    output logic             EXMEMflushOut,
    output logic             mdStartOut,
    output logic             mdErrOut,
    output logic [CNT_W-1:0] stallCycOut,
    output logic [CNT_W-1:0] flushCntOut
);

    // The watchdog counter must be able to hold MD_MAX_CYC itself.
    localparam int WD_W = $clog2(MD_MAX_CYC + 1);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MDWAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              md_issued_q, md_issued_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              md_err_q, md_err_d;

    logic              load_use;
    logic              wd_expired;

    // Load in EX whose destination is read by the instruction in ID; x0 is never a hazard.
    always_comb begin
        load_use = IDEXmemReadIn && (IDEXrdIn != 5'd0) &&
                   ((IFIDuse1In && (IFIDrs1In == IDEXrdIn)) ||
                    (IFIDuse2In && (IFIDrs2In == IDEXrdIn)));
        wd_expired = (wd_cnt_q == WD_W'(MD_MAX_CYC));
    end

    // Next-state and Mealy control decode; rst overrides the outputs to "pipe open".
    always_comb begin
        pcWriteOut    = 1'b1;
        IFIDwriteOut  = 1'b1;
        IFIDflushOut  = 1'b0;
        IDEXwriteOut  = 1'b1;
        IDEXflushOut  = 1'b0;
        EXMEMflushOut = 1'b0;
        mdStartOut    = 1'b0;
        state_d       = state_q;
        md_issued_d   = md_issued_q;
        wd_cnt_d      = wd_cnt_q;
        md_err_d      = md_err_q;

        case (state_q)
            ST_RUN: begin
                if (branchTakenIn) begin
                    // Wrong-path squash; a coincident load-use is moot because
                    // the dependent instruction is being discarded.
                    IFIDflushOut = 1'b1;
                    IDEXflushOut = 1'b1;
                    md_issued_d  = 1'b0;
                end else if (IDEXmdIn && !md_issued_q) begin
                    mdStartOut    = 1'b1;
                    pcWriteOut    = 1'b0;
                    IFIDwriteOut  = 1'b0;
                    IDEXwriteOut  = 1'b0;
                    EXMEMflushOut = 1'b1;
                    md_issued_d   = 1'b1;
                    wd_cnt_d      = WD_W'(1);
                    state_d       = ST_MDWAIT;
                end else if (load_use) begin
                    // One bubble is enough: next cycle the load sits in MEM and
                    // its data can be forwarded.
                    pcWriteOut   = 1'b0;
                    IFIDwriteOut = 1'b0;
                    IDEXflushOut = 1'b1;
                    md_issued_d  = 1'b0;
                end else begin
                    md_issued_d = 1'b0;
                end
            end

            ST_MDWAIT: begin
                pcWriteOut    = 1'b0;
                IFIDwriteOut  = 1'b0;
                IDEXwriteOut  = 1'b0;
                EXMEMflushOut = 1'b1;
                wd_cnt_d      = wd_cnt_q + WD_W'(1);
                if (mdDoneIn || wd_expired) begin
                    // On expiry the pipe advances as if done; the result is undefined
                    // and the sticky error flag records it.
                    pcWriteOut    = 1'b1;
                    IFIDwriteOut  = 1'b1;
                    IDEXwriteOut  = 1'b1;
                    EXMEMflushOut = 1'b0;
                    state_d       = ST_RUN;
                    if (!mdDoneIn) begin
                        md_err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (rst) begin
            pcWriteOut    = 1'b1;
            IFIDwriteOut  = 1'b1;
            IFIDflushOut  = 1'b0;
            IDEXwriteOut  = 1'b1;
            IDEXflushOut  = 1'b0;
            EXMEMflushOut = 1'b0;
            mdStartOut    = 1'b0;
        end
    end

    // State, issued flag, watchdog and sticky error; reset abandons any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            md_issued_q <= 1'b0;
            wd_cnt_q    <= '0;
            md_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            md_issued_q <= md_issued_d;
            wd_cnt_q    <= wd_cnt_d;
            md_err_q    <= md_err_d;
        end
    end

    assign mdErrOut = md_err_q;

`ifdef HZD_PERF_EN
    logic [CNT_W-1:0] stall_cyc_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             branch_flush;

    assign branch_flush = (state_q == ST_RUN) && branchTakenIn && !rst;

    // Free-running performance counters; both wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cyc_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pcWriteOut) begin
                stall_cyc_q <= stall_cyc_q + CNT_W'(1);
            end
            if (branch_flush) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stallCycOut = stall_cyc_q;
    assign flushCntOut = flush_cnt_q;
`else
    assign stallCycOut = '0;
    assign flushCntOut = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with a small expected-value scoreboard.
// Control outputs are packed as {pcW, IFIDw, IFIDflush, IDEXw, IDEXflush, EXMEMflush, mdStart}.
// Counter expectations follow HZD_PERF_EN: zero when the macro is undefined.

module tb_hazard_stall_ctrl;

    localparam int CNT_W = 32;
`ifdef HZD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] C_NORM  = 7'b1101000;
    localparam logic [6:0] C_LU    = 7'b0001100;
    localparam logic [6:0] C_BR    = 7'b1111100;
    localparam logic [6:0] C_START = 7'b0000011;
    localparam logic [6:0] C_WAIT  = 7'b0000010;

    logic             clk = 1'b0;
    logic             rst;
    logic             IDEXmemReadIn;
    logic [4:0]       IDEXrdIn;
    logic             IDEXmdIn;
    logic [4:0]       IFIDrs1In;
    logic [4:0]       IFIDrs2In;
    logic             IFIDuse1In;
    logic             IFIDuse2In;
    logic             branchTakenIn;
    logic             mdDoneIn;
    logic             pcWriteOut;
    logic             IFIDwriteOut;
    logic             IFIDflushOut;
    logic             IDEXwriteOut;
    logic             IDEXflushOut;
    logic             EXMEMflushOut;
    logic             mdStartOut;
    logic             mdErrOut;
    logic [CNT_W-1:0] stallCycOut;
    logic [CNT_W-1:0] flushCntOut;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .MD_MAX_CYC (8),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .IDEXmemReadIn (IDEXmemReadIn),
        .IDEXrdIn      (IDEXrdIn),
        .IDEXmdIn      (IDEXmdIn),
        .IFIDrs1In     (IFIDrs1In),
        .IFIDrs2In     (IFIDrs2In),
        .IFIDuse1In    (IFIDuse1In),
        .IFIDuse2In    (IFIDuse2In),
        .branchTakenIn (branchTakenIn),
        .mdDoneIn      (mdDoneIn),
        .pcWriteOut    (pcWriteOut),
        .IFIDwriteOut  (IFIDwriteOut),
        .IFIDflushOut  (IFIDflushOut),
        .IDEXwriteOut  (IDEXwriteOut),
        .IDEXflushOut  (IDEXflushOut),
        .EXMEMflushOut (EXMEMflushOut),
        .mdStartOut    (mdStartOut),
        .mdErrOut      (mdErrOut),
        .stallCycOut   (stallCycOut),
        .flushCntOut   (flushCntOut)
    );

    typedef struct {
        string            tag;
        logic [6:0]       ctl;
        logic             err;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;
    logic             m_err   = 1'b0;
    logic [6:0]       ctl_obs;

    assign ctl_obs = {pcWriteOut, IFIDwriteOut, IFIDflushOut, IDEXwriteOut,
                      IDEXflushOut, EXMEMflushOut, mdStartOut};

    task automatic push_exp(input string tag, input logic [6:0] ctl);
        exp_t e;
        e.tag   = tag;
        e.ctl   = ctl;
        e.err   = m_err;
        e.stall = m_stall & {CNT_W{PERF}};
        e.flush = m_flush & {CNT_W{PERF}};
        sb.push_back(e);
    endtask

    task automatic check_top();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard empty when output was due");
        end else begin
            e = sb.pop_front();
            checks++;
            assert (ctl_obs === e.ctl) else begin
                errors++;
                $error("FAIL %s ctl observed=%b expected=%b", e.tag, ctl_obs, e.ctl);
            end
            checks++;
            assert (mdErrOut === e.err) else begin
                errors++;
                $error("FAIL %s mdErr observed=%b expected=%b", e.tag, mdErrOut, e.err);
            end
            checks++;
            assert (stallCycOut === e.stall) else begin
                errors++;
                $error("FAIL %s stallCyc observed=%0d expected=%0d", e.tag, stallCycOut, e.stall);
            end
            checks++;
            assert (flushCntOut === e.flush) else begin
                errors++;
                $error("FAIL %s flushCnt observed=%0d expected=%0d", e.tag, flushCntOut, e.flush);
            end
        end
    endtask

    task automatic drive(input logic ld, input logic [4:0] rd, input logic md,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2, input logic br, input logic dn);
        IDEXmemReadIn = ld;
        IDEXrdIn      = rd;
        IDEXmdIn      = md;
        IFIDrs1In     = r1;
        IFIDrs2In     = r2;
        IFIDuse1In    = u1;
        IFIDuse2In    = u2;
        branchTakenIn = br;
        mdDoneIn      = dn;
    endtask

    // One clock cycle: drive after the edge, expect, compare mid-cycle, then
    // advance the counter model by what this cycle contributes at the next edge.
    task automatic step(input string tag, input logic ld, input logic [4:0] rd,
                        input logic md, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic br, input logic dn,
                        input logic [6:0] ctl);
        @(posedge clk);
        #1;
        drive(ld, rd, md, r1, r2, u1, u2, br, dn);
        push_exp(tag, ctl);
        @(negedge clk);
        check_top();
        if (!ctl[6]) m_stall = m_stall + 1'b1;
        if (ctl[4])  m_flush = m_flush + 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset held with a load-use and a MUL/DIV request present: outputs stay open.
        rst = 1'b1;
        drive(1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        push_exp("reset_forced", C_NORM);
        check_top();
        @(negedge clk);
        push_exp("reset_held", C_NORM);
        check_top();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        step("idle",           0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM);
        step("loaduse_rs1",    1, 5'd5, 0, 5'd5, 5'd0, 1, 0, 0, 0, C_LU);
        step("loaduse_after",  0, 5'd0, 0, 5'd5, 5'd0, 1, 0, 0, 0, C_NORM);
        step("load_rd0",       1, 5'd0, 0, 5'd0, 5'd0, 1, 0, 0, 0, C_NORM);
        step("load_nouse",     1, 5'd5, 0, 5'd5, 5'd5, 0, 0, 0, 0, C_NORM);
        step("loaduse_rs2",    1, 5'd7, 0, 5'd1, 5'd7, 1, 1, 0, 0, C_LU);
        step("load_mismatch",  1, 5'd5, 0, 5'd6, 5'd4, 1, 1, 0, 0, C_NORM);
        step("branch_lu",      1, 5'd5, 0, 5'd5, 5'd0, 1, 0, 1, 0, C_BR);

        // MUL/DIV: start, four frozen MDWAIT cycles, done on the fifth -> 5 stall cycles.
        step("md_start",       0, 5'd0, 1, 5'd0, 5'd0, 0, 0, 0, 0, C_START);
        for (int i = 0; i < 4; i++)
            step("md_wait",    0, 5'd0, 1, 5'd0, 5'd0, 0, 0, 0, 0, C_WAIT);
        step("md_done",        0, 5'd0, 1, 5'd0, 5'd0, 0, 0, 0, 1, C_NORM);
        step("md_no_restart",  0, 5'd0, 1, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM);
        step("md_clear",       0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM);
        step("stray_done",     0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, 1, C_NORM);
        step("after_stray",    0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM);

        // Watchdog: no done; the eighth MDWAIT cycle releases the pipe and sets the flag.
        step("wd_start",       0, 5'd0, 1, 5'd0, 5'd0, 0, 0, 0, 0, C_START);
        for (int i = 0; i < 7; i++)
            step("wd_wait",    0, 5'd0, 1, 5'd0, 5'd0, 0, 0, 0, 0, C_WAIT);
        step("wd_expire",      0, 5'd0, 1, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM);
        m_err = 1'b1;
        step("wd_err_set",     0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM);
        step("wd_err_sticky",  1, 5'd9, 0, 5'd9, 5'd0, 1, 0, 0, 0, C_LU);
        step("wd_err_hold",    0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 1, 0, C_BR);

        // Asynchronous reset in the middle of a MUL/DIV wait.
        step("rmd_start",      0, 5'd0, 1, 5'd0, 5'd0, 0, 0, 0, 0, C_START);
        step("rmd_wait",       0, 5'd0, 1, 5'd0, 5'd0, 0, 0, 0, 0, C_WAIT);
        #2;
        rst = 1'b1;
        m_err   = 1'b0;
        m_stall = '0;
        m_flush = '0;
        #1;
        push_exp("async_rst", C_NORM);
        check_top();
        @(posedge clk);
        #1;
        push_exp("async_rst_hold", C_NORM);
        check_top();
        @(negedge clk);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step("post_rst_run",   0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM);
        step("late_done",      0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, 1, C_NORM);
        step("post_late",      0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, 0, C_NORM);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
